// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the SRAM-like instruction/data arbiter.
package sram_like_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  // Which master port owns (or last owned) the bus.
  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } grant_e;

  // Transfer size encoding on every SRAM-like port.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/sram_like_arbiter_grant_sel.sv
// Tie-break logic: picks which requester the arbiter grants while idle.
module sram_like_grant_sel
  import sram_like_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic inst_req,
  input  logic data_req,
  input  logic last_grant,
  output logic grant
);

  // A lone requester always wins; on a tie either data wins or the side
  // not served last wins. With no request the value is irrelevant.
  always_comb begin
    grant = DATA;
    if (inst_req && !data_req) begin
      grant = INST;
    end else if (inst_req && data_req && RR_EN) begin
      grant = (last_grant == INST) ? DATA : INST;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges instruction- and data-side SRAM-like masters onto one SRAM-like bus,
// one outstanding transaction at a time.
//
// Handshake: a master holds req and its request fields until it sees its own
// addr_ok in a cycle where req is high; that cycle is the address transfer.
// data_ok is a single-cycle completion pulse, and rdata is valid only in the
// cycle where the master's own data_ok is high.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  output logic [1:0]        dbg_state
);

  state_e state_q, state_d;
  grant_e last_grant_q, last_grant_d;
  logic   grant;
  logic   own_data;
  logic   gnt_req;

  sram_like_grant_sel #(.RR_EN(RR_EN)) u_grant_sel (
    .inst_req  (inst_req),
    .data_req  (data_req),
    .last_grant(last_grant_q),
    .grant     (grant)
  );

  // State and last-grant registers; reset drops any in-flight ownership.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= INST;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Bus field owner: the current grant while idle, the transaction owner while waiting.
  always_comb begin
    case (state_q)
      WAIT_I:  own_data = 1'b0;
      WAIT_D:  own_data = 1'b1;
      default: own_data = grant;
    endcase
  end

  assign gnt_req   = grant ? data_req : inst_req;
  assign bus_wr    = own_data ? data_wr    : inst_wr;
  assign bus_size  = own_data ? data_size  : inst_size;
  assign bus_addr  = own_data ? data_addr  : inst_addr;
  assign bus_wdata = own_data ? data_wdata : inst_wdata;

  // Read data is broadcast; each side qualifies it with its own data_ok.
  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;
  assign dbg_state  = state_q;

  // Next state, handshake steering and request forwarding.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    bus_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_q)
      IDLE: begin
        bus_req = gnt_req;
        // A bus_data_ok without an accepted address here is a stray ack and is dropped.
        if (gnt_req && bus_addr_ok) begin
          last_grant_d = grant_e'(grant);
          if (grant) data_addr_ok = 1'b1;
          else       inst_addr_ok = 1'b1;
          if (bus_data_ok) begin
            // Zero-wait slave: complete in place and stay idle.
            if (grant) data_data_ok = 1'b1;
            else       inst_data_ok = 1'b1;
          end else begin
            state_d = grant ? WAIT_D : WAIT_I;
          end
        end
      end
      WAIT_I: begin
        inst_data_ok = bus_data_ok;
        if (bus_data_ok) state_d = IDLE;
      end
      WAIT_D: begin
        data_data_ok = bus_data_ok;
        if (bus_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: two instances (fixed data-first and round-robin),
// directed slave responses, and a scoreboard of expected acknowledge events.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  localparam int EW = 51;  // {cycle[15:0], side, kind, wr, value[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals (index 0: RR_EN=0, index 1: RR_EN=1) ----------------
  logic        inst_req[2], inst_wr[2], inst_addr_ok[2], inst_data_ok[2];
  logic [1:0]  inst_size[2];
  logic [31:0] inst_addr[2], inst_wdata[2], inst_rdata[2];
  logic        data_req[2], data_wr[2], data_addr_ok[2], data_data_ok[2];
  logic [1:0]  data_size[2];
  logic [31:0] data_addr[2], data_wdata[2], data_rdata[2];
  logic        bus_req[2], bus_wr[2], bus_addr_ok[2], bus_data_ok[2];
  logic [1:0]  bus_size[2];
  logic [31:0] bus_addr[2], bus_wdata[2], bus_rdata[2];
  logic [1:0]  dbg_state[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(g == 1)) u_dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req[g]), .inst_wr(inst_wr[g]), .inst_size(inst_size[g]),
      .inst_addr(inst_addr[g]), .inst_wdata(inst_wdata[g]), .inst_rdata(inst_rdata[g]),
      .inst_addr_ok(inst_addr_ok[g]), .inst_data_ok(inst_data_ok[g]),
      .data_req(data_req[g]), .data_wr(data_wr[g]), .data_size(data_size[g]),
      .data_addr(data_addr[g]), .data_wdata(data_wdata[g]), .data_rdata(data_rdata[g]),
      .data_addr_ok(data_addr_ok[g]), .data_data_ok(data_data_ok[g]),
      .bus_req(bus_req[g]), .bus_wr(bus_wr[g]), .bus_size(bus_size[g]),
      .bus_addr(bus_addr[g]), .bus_wdata(bus_wdata[g]), .bus_rdata(bus_rdata[g]),
      .bus_addr_ok(bus_addr_ok[g]), .bus_data_ok(bus_data_ok[g]),
      .dbg_state(dbg_state[g])
    );
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  task automatic push(input int d, input int c, input logic side, input logic kind,
                      input logic wr, input logic [31:0] v);
    logic [EW-1:0] ev;
    ev = {c[15:0], side, kind, wr, v};
    if (d == 0) exp_q0.push_back(ev);
    else        exp_q1.push_back(ev);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // One observed acknowledge (kind 0 = addr_ok, 1 = data_ok) against the queue head.
  task automatic observe(input int d, input logic side, input logic kind);
    logic [EW-1:0] act;
    logic [EW-1:0] exp_v;
    logic [31:0]   v;
    logic          wr;
    if (!kind) begin
      v  = bus_addr[d];
      wr = bus_wr[d];
    end else begin
      v  = side ? data_rdata[d] : inst_rdata[d];
      wr = 1'b0;
    end
    act = {cyc[15:0], side, kind, wr, v};
    checks++;
    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
      errors++;
      $display("FAIL sb_dut%0d unexpected ack: got %h expected none", d, act);
    end else begin
      exp_v = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (act !== exp_v) begin
        errors++;
        $display("FAIL sb_dut%0d event: got %h expected %h", d, act, exp_v);
      end
    end
  endtask

  // Monitor: samples acknowledges mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (inst_addr_ok[d]) observe(d, 1'b0, 1'b0);
      if (data_addr_ok[d]) observe(d, 1'b1, 1'b0);
      if (inst_data_ok[d]) observe(d, 1'b0, 1'b1);
      if (data_data_ok[d]) observe(d, 1'b1, 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      inst_req[d] = 1'b0; inst_wr[d] = 1'b0; inst_size[d] = SZ_WORD;
      inst_addr[d] = '0;  inst_wdata[d] = '0;
      data_req[d] = 1'b0; data_wr[d] = 1'b0; data_size[d] = SZ_WORD;
      data_addr[d] = '0;  data_wdata[d] = '0;
      bus_addr_ok[d] = 1'b0; bus_data_ok[d] = 1'b0; bus_rdata[d] = '0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          c0;
    logic [3:0]  rr_seq;
    logic        s;
    rr_seq = 4'b0101;  // bit k = expected grant of transaction k (1 = DATA)

    // Reset
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    settle();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_state%0d", d), 32'(dbg_state[d]), 32'(IDLE));
      chk($sformatf("rst_bus_req%0d", d), 32'(bus_req[d]), 32'd0);
      chk($sformatf("rst_ack%0d", d),
          32'({inst_addr_ok[d], data_addr_ok[d], inst_data_ok[d], data_data_ok[d]}), 32'd0);
    end
    tick();
    resetn = 1'b1;

    // Instruction side alone: addr_ok at cycle 1, data_ok at cycle 3
    tick(); c0 = cyc;
    inst_req[0] = 1'b1; inst_addr[0] = 32'hBFC00000; inst_size[0] = SZ_WORD;
    settle();
    chk("t1_bus_req", 32'(bus_req[0]), 32'd1);
    chk("t1_bus_addr", bus_addr[0], 32'hBFC00000);
    tick(); bus_addr_ok[0] = 1'b1;
    push(0, c0 + 1, 1'b0, 1'b0, 1'b0, 32'hBFC00000);
    tick(); inst_req[0] = 1'b0; bus_addr_ok[0] = 1'b0;
    settle();
    chk("t1_wait_i", 32'(dbg_state[0]), 32'(WAIT_I));
    chk("t1_wait_bus_req", 32'(bus_req[0]), 32'd0);
    tick(); bus_data_ok[0] = 1'b1; bus_rdata[0] = 32'h3C1D0001;
    push(0, c0 + 3, 1'b0, 1'b1, 1'b0, 32'h3C1D0001);
    tick(); bus_data_ok[0] = 1'b0;
    settle();
    chk("t1_back_idle", 32'(dbg_state[0]), 32'(IDLE));

    // Simultaneous requests, data-first; instruction waits through WAIT_D
    tick(); c0 = cyc;
    inst_req[0] = 1'b1; inst_addr[0] = 32'hBFC00010;
    data_req[0] = 1'b1; data_wr[0] = 1'b1; data_size[0] = SZ_WORD;
    data_addr[0] = 32'h80001000; data_wdata[0] = 32'h5A5A0F0F;
    bus_addr_ok[0] = 1'b1;
    push(0, c0, 1'b1, 1'b0, 1'b1, 32'h80001000);
    settle();
    chk("t2_bus_size", 32'(bus_size[0]), 32'(SZ_WORD));
    chk("t2_bus_wdata", bus_wdata[0], 32'h5A5A0F0F);
    tick(); data_req[0] = 1'b0; data_wr[0] = 1'b0; bus_addr_ok[0] = 1'b0;
    settle();
    chk("t2_wait_d", 32'(dbg_state[0]), 32'(WAIT_D));
    chk("t2_wait_bus_req", 32'(bus_req[0]), 32'd0);
    tick(); bus_data_ok[0] = 1'b1; bus_rdata[0] = 32'h11112222;
    push(0, c0 + 2, 1'b1, 1'b1, 1'b0, 32'h11112222);
    settle();
    chk("t2_done_bus_req", 32'(bus_req[0]), 32'd0);
    tick(); bus_data_ok[0] = 1'b0; bus_addr_ok[0] = 1'b1;
    push(0, c0 + 3, 1'b0, 1'b0, 1'b0, 32'hBFC00010);
    tick(); inst_req[0] = 1'b0; bus_addr_ok[0] = 1'b0;
    tick(); bus_data_ok[0] = 1'b1; bus_rdata[0] = 32'hAAAA5555;
    push(0, c0 + 5, 1'b0, 1'b1, 1'b0, 32'hAAAA5555);
    tick(); bus_data_ok[0] = 1'b0;

    // Zero-wait slave, instruction side, two requests back to back
    tick(); c0 = cyc;
    inst_req[0] = 1'b1; inst_addr[0] = 32'hBFC00100;
    bus_addr_ok[0] = 1'b1; bus_data_ok[0] = 1'b1; bus_rdata[0] = 32'h0BADF00D;
    push(0, c0, 1'b0, 1'b0, 1'b0, 32'hBFC00100);
    push(0, c0, 1'b0, 1'b1, 1'b0, 32'h0BADF00D);
    tick();
    inst_addr[0] = 32'hBFC00104; bus_rdata[0] = 32'h12345678;
    push(0, c0 + 1, 1'b0, 1'b0, 1'b0, 32'hBFC00104);
    push(0, c0 + 1, 1'b0, 1'b1, 1'b0, 32'h12345678);
    settle();
    chk("t4_stay_idle", 32'(dbg_state[0]), 32'(IDLE));
    tick(); inst_req[0] = 1'b0; bus_addr_ok[0] = 1'b0; bus_data_ok[0] = 1'b0;
    settle();
    chk("t4_idle_after", 32'(dbg_state[0]), 32'(IDLE));

    // Round-robin with both sides requesting continuously
    tick();
    inst_req[1] = 1'b1; inst_addr[1] = 32'h00400000;
    data_req[1] = 1'b1; data_addr[1] = 32'h10010000;
    for (int k = 0; k < 4; k++) begin
      s = rr_seq[k];
      tick(); bus_addr_ok[1] = 1'b1; bus_data_ok[1] = 1'b0;
      push(1, cyc, s, 1'b0, 1'b0, s ? 32'h10010000 : 32'h00400000);
      tick(); bus_addr_ok[1] = 1'b0; bus_data_ok[1] = 1'b1; bus_rdata[1] = 32'hC0DE0000 + k;
      push(1, cyc, s, 1'b1, 1'b0, 32'hC0DE0000 + k);
      settle();
      chk($sformatf("t3_wait_bus_req%0d", k), 32'(bus_req[1]), 32'd0);
    end
    tick(); inst_req[1] = 1'b0; data_req[1] = 1'b0; bus_data_ok[1] = 1'b0;

    // Reset pulse during WAIT_I, then a late bus_data_ok
    tick();
    inst_req[0] = 1'b1; inst_addr[0] = 32'hBFC00200; bus_addr_ok[0] = 1'b1;
    push(0, cyc, 1'b0, 1'b0, 1'b0, 32'hBFC00200);
    tick(); inst_req[0] = 1'b0; bus_addr_ok[0] = 1'b0;
    settle();
    chk("t6_wait_i", 32'(dbg_state[0]), 32'(WAIT_I));
    #1 resetn = 1'b0;
    #1;
    chk("t6_async_idle", 32'(dbg_state[0]), 32'(IDLE));
    tick(); resetn = 1'b1;
    tick(); bus_data_ok[0] = 1'b1; bus_rdata[0] = 32'hDEADBEEF;
    settle();
    chk("t6_no_inst_data_ok", 32'(inst_data_ok[0]), 32'd0);
    chk("t6_no_data_data_ok", 32'(data_data_ok[0]), 32'd0);
    chk("t6_idle", 32'(dbg_state[0]), 32'(IDLE));
    tick(); bus_data_ok[0] = 1'b0;

    // Final report
    repeat (2) tick();
    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Merges the CPU's instruction-side and data-side SRAM-like master ports onto one SRAM-like slave bus.
- Sits between the two sram-to-sram-like bridges and the single SRAM-like-to-AXI interface.
- Allows one outstanding transaction at a time.
- Tie-break on simultaneous requests is fixed data-first or round-robin, selected by parameter.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- RR_EN, 0:
  - 0 = data side always wins a tie.
  - 1 = round-robin: the side not granted last wins a tie.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction-side request
- inst_wr  in  1  instruction-side write (tied 0 in the CPU; still arbitrated)
- inst_size  in  2  instruction-side size: 00 byte, 01 half, 10 word
- inst_addr  in  ADDR_W  instruction-side address
- inst_wdata  in  DATA_W  instruction-side write data
- inst_rdata  out  DATA_W  instruction-side read data
- inst_addr_ok  out  1  instruction-side address accepted
- inst_data_ok  out  1  instruction-side transaction done
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/ADDR_W/DATA_W  data-side request fields, same meaning as the instruction side
- data_rdata  out  DATA_W  data-side read data
- data_addr_ok  out  1  data-side address accepted
- data_data_ok  out  1  data-side transaction done
- bus_req, bus_wr, bus_size, bus_addr, bus_wdata  out  1/1/2/ADDR_W/DATA_W  merged request toward the slave
- bus_rdata  in  DATA_W  slave read data
- bus_addr_ok  in  1  slave address accepted
- bus_data_ok  in  1  slave transaction done

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, last_grant=INST.
  - Consequently bus_req=0 and all *_addr_ok / *_data_ok = 0.
- States:
  - IDLE
  - WAIT_I: instruction address accepted, awaiting data_ok.
  - WAIT_D: data address accepted, awaiting data_ok.
- Grant selection (combinational, meaningful in IDLE only):
  - Only one side requesting: that side is granted.
  - Both requesting, RR_EN=0: data side is granted.
  - Both requesting, RR_EN=1: the side opposite to last_grant is granted.
- IDLE outputs:
  - bus_req = req of the granted side.
  - bus_wr/size/addr/wdata = muxed from the granted side.
  - Granted side's addr_ok = bus_addr_ok.
  - Ungranted side's addr_ok = 0.
- IDLE transitions:
  - bus_addr_ok & ~bus_data_ok: go to WAIT_I or WAIT_D per grant; last_grant <= grant.
  - bus_addr_ok & bus_data_ok in the same cycle (zero-wait slave): stay IDLE; the granted side's data_ok is asserted that cycle; last_grant <= grant.
  - No bus_addr_ok: stay IDLE; grant may change the next cycle if requests change.
- WAIT_x:
  - bus_req=0; request fields hold the owner's values.
  - Both addr_ok = 0.
  - Owner's data_ok = bus_data_ok; the other side's data_ok = 0.
  - On bus_data_ok: return to IDLE. The next grant occurs the following cycle, so there is one bubble between back-to-back transactions.
- Read data:
  - inst_rdata = data_rdata = bus_rdata (broadcast).
  - Qualify only with the own data_ok.
- Stray bus_data_ok in IDLE without addr_ok: ignored; no data_ok to either side.
- Requesters must hold their request fields until their addr_ok; the arbiter does not latch them.
- A request dropped before addr_ok simply loses arbitration.
- resetn asserted mid-transaction: immediate return to IDLE; any later bus_data_ok for that transaction is discarded by the stray-ack rule.
- bus_req is never asserted outside IDLE, so at most one transaction is outstanding.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'd0, WAIT_I=2'd1, WAIT_D=2'd2.
  - Grant encoding: INST=1'b0, DATA=1'b1.
  - Size constants: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
- One natural sub-module: sram_like_grant_sel.
  - Inputs: inst_req, data_req, last_grant, RR_EN.
  - Output: grant.
- The FSM and the muxes stay in the top module.

Test Plan:
- Only inst_req=1, addr 0xBFC00000, slave addr_ok at cycle 1 and data_ok at cycle 3 with rdata 0x3C1D0001:
  - inst_addr_ok at cycle 1.
  - inst_data_ok at cycle 3.
  - data_* acks stay 0 throughout.
- Both requesting in the same cycle, RR_EN=0, data_wr=1, data_addr 0x80001000, data_size 10:
  - bus_addr = 0x80001000, bus_wr=1.
  - Data side completes first.
  - Instruction side is granted in the cycle after data_data_ok.
- Both requesting continuously for 4 transactions, RR_EN=1: grant sequence is DATA, INST, DATA, INST (last_grant reset=INST).
- Zero-wait slave (addr_ok and data_ok in the same cycle), instruction side only:
  - inst_addr_ok and inst_data_ok asserted the same cycle.
  - FSM stays IDLE.
  - Next request granted the next cycle.
- In WAIT_D, assert inst_req:
  - bus_req=0 and inst_addr_ok=0 until data_data_ok.
  - Instruction side granted the following cycle.
- resetn pulsed low during WAIT_I, then bus_data_ok arrives:
  - Immediate IDLE.
  - No inst_data_ok or data_data_ok is emitted.
